// File: rtl/kw_lookup_ctrl.sv
// Streaming identifier collector that sweeps a synchronous keyword ROM and emits one
// classification record per token. Optional `KW_CASE_FOLD_EN folds A-Z to a-z on store.
module kw_lookup_ctrl #(
    parameter int MAXLEN = 12,
    parameter int NKW    = 102,
    parameter int AW     = 7,
    parameter int LW     = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          in_char,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic [AW-1:0]       rom_addr,
    input  logic [8*MAXLEN-1:0] rom_data,
    input  logic [LW-1:0]       rom_len,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_kw,
    output logic [AW-1:0]       out_idx,
    output logic [LW-1:0]       out_len,
    output logic                out_ovf
);

    localparam logic [LW-1:0] MAXLEN_L = LW'(MAXLEN);
    localparam logic [AW-1:0] LAST_IDX = AW'(NKW - 1);

    typedef enum logic [1:0] {COLLECT, SEARCH, EMIT} state_t;
    state_t state, state_nxt;

    logic [8*MAXLEN-1:0] tok_buf;
    logic [LW-1:0]       tok_len;
    logic                tok_ovf;
    logic                cmp_vld;
    logic [AW-1:0]       cmp_idx;

    logic                is_id;
    logic [7:0]          char_st;
    logic                accept;
    logic                full;
    logic                close;
    logic                ovf_close;
    logic [MAXLEN-1:0]   byte_eq;
    logic                match;
    logic                last_cmp;

    always_comb begin
        is_id = ((in_char >= 8'h61) && (in_char <= 8'h7A)) ||
                ((in_char >= 8'h41) && (in_char <= 8'h5A)) ||
                ((in_char >= 8'h30) && (in_char <= 8'h39)) ||
                (in_char == 8'h5F) || (in_char == 8'h24);
    end

`ifdef KW_CASE_FOLD_EN
    assign char_st = ((in_char >= 8'h41) && (in_char <= 8'h5A)) ? (in_char | 8'h20) : in_char;
`else
    assign char_st = in_char;
`endif

    assign accept    = in_valid && (state == COLLECT);
    assign full      = (tok_len == MAXLEN_L);
    // A token closes on a delimiter after content, or on in_last riding an identifier char.
    assign close     = accept && (is_id ? in_last : (tok_len != '0));
    assign ovf_close = tok_ovf || (is_id && full);

    // Bytes at or past the token length are ignored so ROM padding never matters.
    for (genvar i = 0; i < MAXLEN; i++) begin : g_cmp
        assign byte_eq[i] = (LW'(i) >= tok_len) ||
                            (rom_data[8*i +: 8] == tok_buf[8*i +: 8]);
    end

    assign match    = cmp_vld && (rom_len == tok_len) && (&byte_eq);
    assign last_cmp = cmp_vld && (cmp_idx == LAST_IDX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= COLLECT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            COLLECT: begin
                in_ready = 1'b1;
                if (close) state_nxt = ovf_close ? EMIT : SEARCH;
            end
            SEARCH:  if (match || last_cmp) state_nxt = EMIT;
            EMIT:    if (out_ready) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tok_buf   <= '0;
            tok_len   <= '0;
            tok_ovf   <= 1'b0;
            rom_addr  <= '0;
            cmp_vld   <= 1'b0;
            cmp_idx   <= '0;
            out_valid <= 1'b0;
            out_kw    <= 1'b0;
            out_idx   <= '0;
            out_len   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                COLLECT: if (accept) begin
                    if (is_id) begin
                        for (int i = 0; i < MAXLEN; i++)
                            if (tok_len == LW'(i)) tok_buf[8*i +: 8] <= char_st;
                        if (full) tok_ovf <= 1'b1;
                        else      tok_len <= tok_len + 1'b1;
                    end
                    if (close) begin
                        if (ovf_close) begin
                            out_valid <= 1'b1;
                            out_kw    <= 1'b0;
                            out_idx   <= '0;
                            out_len   <= MAXLEN_L;
                            out_ovf   <= 1'b1;
                            tok_buf   <= '0;
                            tok_len   <= '0;
                            tok_ovf   <= 1'b0;
                        end else begin
                            rom_addr <= '0;
                            cmp_vld  <= 1'b0;
                        end
                    end
                end
                SEARCH: begin
                    // Data returned this cycle belongs to the address issued last cycle.
                    cmp_vld <= 1'b1;
                    cmp_idx <= rom_addr;
                    if (rom_addr != LAST_IDX) rom_addr <= rom_addr + 1'b1;
                    if (match || last_cmp) begin
                        out_valid <= 1'b1;
                        out_kw    <= match;
                        out_idx   <= match ? cmp_idx : '0;
                        out_len   <= tok_len;
                        out_ovf   <= 1'b0;
                        tok_buf   <= '0;
                        tok_len   <= '0;
                        tok_ovf   <= 1'b0;
                        rom_addr  <= '0;
                        cmp_vld   <= 1'b0;
                    end
                end
                EMIT: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
